// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with whole-vector key debounce and per-bit button debounce.
// Optional KEYPAD_GHOST_REJECT_EN: frames with more than two keys pressed are discarded.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 5000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  col_n,
  input  logic [4:0]  button_raw,
  output logic [3:0]  row_n,
  output logic [15:0] keyboard,
  output logic [4:0]  button,
  output logic        frame_done
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0]          col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [4:0]          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [3:0]          row_n_q, row_n_d;
  logic [15:0]         frame_acc_q, frame_acc_d;
  logic [15:0]         prev_frame_q, prev_frame_d;
  logic [CW-1:0]       key_cnt_q, key_cnt_d;
  logic [15:0]         keyboard_q, keyboard_d;
  logic [4:0]          btn_prev_q, btn_prev_d;
  logic [4:0][CW-1:0]  btn_cnt_q, btn_cnt_d;
  logic [4:0]          button_q, button_d;
  logic                frame_done_q, frame_done_d;

  logic                capture;
  logic                ghost;
  logic [15:0]         frame_now;

  always_comb begin
    col_s1_d     = col_n;
    col_s2_d     = col_s1_q;
    btn_s1_d     = button_raw;
    btn_s2_d     = btn_s1_q;
    div_cnt_d    = div_cnt_q;
    row_idx_d    = row_idx_q;
    row_n_d      = row_n_q;
    frame_acc_d  = frame_acc_q;
    prev_frame_d = prev_frame_q;
    key_cnt_d    = key_cnt_q;
    keyboard_d   = keyboard_q;
    btn_prev_d   = btn_prev_q;
    btn_cnt_d    = btn_cnt_q;
    button_d     = button_q;
    frame_done_d = 1'b0;
    ghost        = 1'b0;

    capture   = (div_cnt_q == DIV_LAST);
    frame_now = frame_acc_q;
    frame_now[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;

    div_cnt_d = capture ? '0 : div_cnt_q + DW'(1);

    if (capture) begin
      frame_acc_d = frame_now;
      row_idx_d   = row_idx_q + 2'd1;
      row_n_d     = ~(4'b0001 << row_idx_d);
    end

    // Row 3 capture completes the frame; all debounce state advances once per frame.
    if (capture && (row_idx_q == 2'd3)) begin
      frame_done_d = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
      ghost = ($countones(frame_now) > 2);
`endif
      if (ghost) begin
        key_cnt_d = '0;
      end else begin
        if (frame_now == prev_frame_q)
          key_cnt_d = (key_cnt_q == DB_MAX) ? DB_MAX : key_cnt_q + CNT_ONE;
        else
          key_cnt_d = CNT_ONE;
        prev_frame_d = frame_now;
        if (key_cnt_d == DB_MAX)
          keyboard_d = frame_now;
      end

      for (int unsigned i = 0; i < 5; i++) begin
        if (btn_s2_q[i] == btn_prev_q[i])
          btn_cnt_d[i] = (btn_cnt_q[i] == DB_MAX) ? DB_MAX : btn_cnt_q[i] + CNT_ONE;
        else
          btn_cnt_d[i] = CNT_ONE;
        btn_prev_d[i] = btn_s2_q[i];
        if (btn_cnt_d[i] == DB_MAX)
          button_d[i] = btn_s2_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_s1_q     <= '1;
      col_s2_q     <= '1;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      div_cnt_q    <= '0;
      row_idx_q    <= '0;
      row_n_q      <= 4'b1110;
      frame_acc_q  <= '0;
      prev_frame_q <= '0;
      key_cnt_q    <= '0;
      keyboard_q   <= '0;
      btn_prev_q   <= '0;
      btn_cnt_q    <= '0;
      button_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_s1_q     <= col_s1_d;
      col_s2_q     <= col_s2_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      div_cnt_q    <= div_cnt_d;
      row_idx_q    <= row_idx_d;
      row_n_q      <= row_n_d;
      frame_acc_q  <= frame_acc_d;
      prev_frame_q <= prev_frame_d;
      key_cnt_q    <= key_cnt_d;
      keyboard_q   <= keyboard_d;
      btn_prev_q   <= btn_prev_d;
      btn_cnt_q    <= btn_cnt_d;
      button_q     <= button_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_n      = row_n_q;
  assign keyboard   = keyboard_q;
  assign button     = button_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  col_n;
  logic [4:0]  button_raw;
  logic [3:0]  row_n;
  logic [15:0] keyboard;
  logic [4:0]  button;
  logic        frame_done;
  logic [15:0] pressed;

  int unsigned errors = 0;
  int unsigned checks = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .col_n      (col_n),
    .button_raw (button_raw),
    .row_n      (row_n),
    .keyboard   (keyboard),
    .button     (button),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Passive matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    check("frame_wait", 16'(frame_done), 16'h0001);
  endtask

  initial begin
    reset = 1'b1;
    pressed = '0;
    button_raw = '0;
    repeat (3) tick();
    check("rst_keyboard",   keyboard,          16'h0000);
    check("rst_button",     16'(button),       16'h0000);
    check("rst_frame_done", 16'(frame_done),   16'h0000);
    check("rst_row_n",      16'(row_n),        16'h000e);

    reset = 1'b0;
    repeat (3) tick();
    check("row0_hold", 16'(row_n), 16'h000e);
    tick();
    check("row1", 16'(row_n), 16'h000d);
    repeat (4) tick();
    check("row2", 16'(row_n), 16'h000b);
    repeat (4) tick();
    check("row3", 16'(row_n), 16'h0007);
    repeat (3) tick();
    check("fd_not_yet", 16'(frame_done), 16'h0000);
    tick();
    check("fd_first", 16'(frame_done), 16'h0001);
    check("row_wrap", 16'(row_n), 16'h000e);
    tick();
    check("fd_pulse_end", 16'(frame_done), 16'h0000);
    repeat (15) tick();
    check("fd_second", 16'(frame_done), 16'h0001);

    for (int f = 0; f < 10; f++) begin
      pressed = (f % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_frame();
      check("bounce", keyboard, 16'h0000);
    end

    pressed = 16'h0040;
    wait_frame(); check("press_f1", keyboard, 16'h0000);
    wait_frame(); check("press_f2", keyboard, 16'h0000);
    wait_frame(); check("press_f3", keyboard, 16'h0040);

    pressed = 16'h0000;
    wait_frame(); check("release_f1", keyboard, 16'h0040);
    wait_frame(); check("release_f2", keyboard, 16'h0040);
    wait_frame(); check("release_f3", keyboard, 16'h0000);

    button_raw = 5'b00001;
    wait_frame(); check("btn_glitch_f1", 16'(button), 16'h0000);
    button_raw = 5'b00000;
    wait_frame(); check("btn_glitch_f2", 16'(button), 16'h0000);
    button_raw = 5'b00001;
    wait_frame(); check("btn_hold_f1", 16'(button), 16'h0000);
    button_raw = 5'b10001;
    wait_frame(); check("btn_hold_f2", 16'(button), 16'h0000);
    wait_frame(); check("btn_hold_f3", 16'(button), 16'h0001);
    wait_frame(); check("btn_both",    16'(button), 16'h0011);

    pressed = 16'h0040;
    repeat (3) wait_frame();
    check("repress", keyboard, 16'h0040);

    begin
      int n = 0;
      while (row_n !== 4'b1011 && n < 40) begin
        tick();
        n++;
      end
    end
    check("midscan_reach", 16'(row_n), 16'h000b);
    reset = 1'b1;
    tick();
    check("midscan_row_n",      16'(row_n),      16'h000e);
    check("midscan_keyboard",   keyboard,        16'h0000);
    check("midscan_button",     16'(button),     16'h0000);
    check("midscan_frame_done", 16'(frame_done), 16'h0000);
    reset = 1'b0;
    pressed = '0;
    button_raw = '0;
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      check("post_reset_kbd", keyboard, 16'h0000);
    end

    pressed = 16'h0013;
    for (int f = 0; f < 5; f++) begin
      wait_frame();
`ifdef KEYPAD_GHOST_REJECT_EN
      check("ghost", keyboard, 16'h0000);
`else
      check("ghost", keyboard, (f >= 2) ? 16'h0013 : 16'h0000);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
